entry_sequencer: RTL and testbench

ENTRY_SEQUENCER -- requirements
Module: entry_sequencer

---
 rtl/entry_pkg.sv | 27 ++
 rtl/cycle_timer.sv | 39 +++
 rtl/entry_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_entry_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/entry_pkg.sv
// Shared definitions for the keypad entry sequencer: FSM state codes,
// special key codes, the blank display digit and small value helpers.
package entry_pkg;

    typedef enum logic [7:0] {
        ST_IDLE = 8'h00,
        ST_ONE  = 8'h01,
        ST_TWO  = 8'h02,
        ST_SHOW = 8'h04
    } entry_state_e;

    localparam logic [3:0] KEY_CLEAR   = 4'hA;
    localparam logic [3:0] KEY_ENTER   = 4'hB;
    localparam logic [3:0] BLANK_DIGIT = 4'hA;

    // Decimal digit keys are 0-9; anything above is a command or ignored.
    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

    // Combines tens and units digits into a 0-99 value.
    function automatic logic [6:0] two_digit_value(input logic [3:0] tens,
                                                   input logic [3:0] ones);
        return (7'(tens) * 7'd10) + 7'(ones);
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Down-counting interval timer. A load arms it for CYCLES enabled cycles;
// done is raised during the last of those cycles. Load wins over counting.
module cycle_timer #(
    parameter int unsigned CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic enable_i,
    output logic done_o
);

    localparam int unsigned CountW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CountW-1:0] LoadVal = CountW'(CYCLES - 1);

    logic [CountW-1:0] count_q, count_d;

    // Reload on request, otherwise count down while enabled and stop at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = LoadVal;
        end else if (enable_i && (count_q != '0)) begin
            count_d = count_q - CountW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = enable_i && (count_q == '0);

endmodule

// File: rtl/entry_sequencer.sv
// Two-digit keypad entry sequencer. Collects up to two decimal digits,
// accepts them on ENTER, shows the accepted value for SHOW_CYCLES cycles,
// and blanks the display on CLEAR or when the show period ends.
// Optional feature: define ENTRY_TIMEOUT_EN to abandon a partial entry after
// TIMEOUT_CYCLES cycles without any key strobe.
module entry_sequencer
    import entry_pkg::*;
#(
    parameter int unsigned SHOW_CYCLES    = 100000000,
    parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       digit_changed,
    output logic [3:0] number_input,
    output logic       two_digit_clear,
    output logic       disp_val,
    output logic [3:0] first_val_digit,
    output logic [3:0] second_val_digit,
    output logic [7:0] state,
    output logic       code_valid,
    output logic [6:0] code_value,
    output logic       timeout
);

    if (SHOW_CYCLES == 0 || TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("entry_sequencer: SHOW_CYCLES and TIMEOUT_CYCLES must be nonzero");
    end

    entry_state_e state_q, state_d;
    logic [3:0]   d0_q, d0_d;
    logic [3:0]   d1_q, d1_d;
    logic         digit_changed_q, digit_changed_d;
    logic [3:0]   number_input_q, number_input_d;
    logic         two_digit_clear_q, two_digit_clear_d;
    logic         disp_val_q, disp_val_d;
    logic [3:0]   first_q, first_d;
    logic [3:0]   second_q, second_d;
    logic         code_valid_q, code_valid_d;
    logic [6:0]   code_value_q, code_value_d;

    logic show_load;
    logic show_done;
    logic entry_timed_out;
    logic clear_key;

    assign clear_key = key_valid && (key_code == KEY_CLEAR);

    cycle_timer #(
        .CYCLES(SHOW_CYCLES)
    ) u_show_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (show_load),
        .enable_i(state_q == ST_SHOW),
        .done_o  (show_done)
    );

`ifdef ENTRY_TIMEOUT_EN
    logic idle_done;
    logic timeout_q;

    cycle_timer #(
        .CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (key_valid),
        .enable_i((state_q == ST_ONE) || (state_q == ST_TWO)),
        .done_o  (idle_done)
    );

    // A key arriving in the expiry cycle keeps the entry alive.
    assign entry_timed_out = idle_done && !key_valid;

    // Registered abort strobe, aligned with the blank strobe it accompanies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= entry_timed_out;
        end
    end

    assign timeout = timeout_q;
`else
    assign entry_timed_out = 1'b0;
    assign timeout         = 1'b0;
`endif

    // Next-state and registered-output logic. CLEAR, show expiry and entry
    // timeout all collapse into one return-to-idle path so a single blank
    // strobe is issued even when they coincide.
    always_comb begin
        state_d           = state_q;
        d0_d              = d0_q;
        d1_d              = d1_q;
        digit_changed_d   = 1'b0;
        number_input_d    = number_input_q;
        two_digit_clear_d = 1'b0;
        disp_val_d        = disp_val_q;
        first_d           = first_q;
        second_d          = second_q;
        code_valid_d      = 1'b0;
        code_value_d      = code_value_q;
        show_load         = 1'b0;

        if (clear_key || show_done || entry_timed_out) begin
            state_d           = ST_IDLE;
            d0_d              = 4'd0;
            d1_d              = 4'd0;
            two_digit_clear_d = 1'b1;
            disp_val_d        = 1'b0;
            first_d           = BLANK_DIGIT;
            second_d          = BLANK_DIGIT;
        end else if (key_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_digit(key_code)) begin
                        state_d         = ST_ONE;
                        d0_d            = key_code;
                        digit_changed_d = 1'b1;
                        number_input_d  = key_code;
                    end
                end
                ST_ONE: begin
                    if (is_digit(key_code)) begin
                        state_d         = ST_TWO;
                        d1_d            = d0_q;
                        d0_d            = key_code;
                        digit_changed_d = 1'b1;
                        number_input_d  = key_code;
                    end else if (key_code == KEY_ENTER) begin
                        state_d      = ST_SHOW;
                        code_value_d = {3'b000, d0_q};
                        first_d      = BLANK_DIGIT;
                        second_d     = d0_q;
                        code_valid_d = 1'b1;
                        disp_val_d   = 1'b1;
                        show_load    = 1'b1;
                        d0_d         = 4'd0;
                        d1_d         = 4'd0;
                    end
                end
                ST_TWO: begin
                    if (key_code == KEY_ENTER) begin
                        state_d      = ST_SHOW;
                        code_value_d = two_digit_value(d1_q, d0_q);
                        first_d      = d1_q;
                        second_d     = d0_q;
                        code_valid_d = 1'b1;
                        disp_val_d   = 1'b1;
                        show_load    = 1'b1;
                        d0_d         = 4'd0;
                        d1_d         = 4'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and output registers; reset abandons any entry or show silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= ST_IDLE;
            d0_q              <= 4'd0;
            d1_q              <= 4'd0;
            digit_changed_q   <= 1'b0;
            number_input_q    <= 4'd0;
            two_digit_clear_q <= 1'b0;
            disp_val_q        <= 1'b0;
            first_q           <= BLANK_DIGIT;
            second_q          <= BLANK_DIGIT;
            code_valid_q      <= 1'b0;
            code_value_q      <= 7'd0;
        end else begin
            state_q           <= state_d;
            d0_q              <= d0_d;
            d1_q              <= d1_d;
            digit_changed_q   <= digit_changed_d;
            number_input_q    <= number_input_d;
            two_digit_clear_q <= two_digit_clear_d;
            disp_val_q        <= disp_val_d;
            first_q           <= first_d;
            second_q          <= second_d;
            code_valid_q      <= code_valid_d;
            code_value_q      <= code_value_d;
        end
    end

    assign digit_changed    = digit_changed_q;
    assign number_input     = number_input_q;
    assign two_digit_clear  = two_digit_clear_q;
    assign disp_val         = disp_val_q;
    assign first_val_digit  = first_q;
    assign second_val_digit = second_q;
    assign state            = state_q;
    assign code_valid       = code_valid_q;
    assign code_value       = code_value_q;

endmodule

// File: tb/tb_entry_sequencer.sv
// Testbench for entry_sequencer with short show/timeout periods.
// Honours ENTRY_TIMEOUT_EN when choosing timeout expectations.
`timescale 1ns/1ps
module tb_entry_sequencer;

    localparam int unsigned SHOW_N    = 8;
    localparam int unsigned TIMEOUT_N = 16;
`ifdef ENTRY_TIMEOUT_EN
    localparam bit TimeoutOn = 1'b1;
`else
    localparam bit TimeoutOn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       digit_changed;
    logic [3:0] number_input;
    logic       two_digit_clear;
    logic       disp_val;
    logic [3:0] first_val_digit;
    logic [3:0] second_val_digit;
    logic [7:0] state;
    logic       code_valid;
    logic [6:0] code_value;
    logic       timeout;

    entry_sequencer #(
        .SHOW_CYCLES   (SHOW_N),
        .TIMEOUT_CYCLES(TIMEOUT_N)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .key_valid       (key_valid),
        .key_code        (key_code),
        .digit_changed   (digit_changed),
        .number_input    (number_input),
        .two_digit_clear (two_digit_clear),
        .disp_val        (disp_val),
        .first_val_digit (first_val_digit),
        .second_val_digit(second_val_digit),
        .state           (state),
        .code_valid      (code_valid),
        .code_value      (code_value),
        .timeout         (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       dc;
        logic [3:0] num;
        logic       clr;
        logic       disp;
        logic [3:0] first;
        logic [3:0] second;
        logic [7:0] st;
        logic       cv;
        logic [6:0] val;
        logic       to;
    } obs_t;

    typedef struct {
        bit         kv;
        logic [3:0] code;
        int         reps;
        bit         chk;
        obs_t       expv;
        string      name;
    } vec_t;

    int testsRun = 0;
    int testsFailed = 0;
    vec_t vecs[$];

    // Reference model: pending digits kept as a list, show time as a countdown.
    int   mDigits[$];
    bit   mShowing;
    int   mShowLeft;
    int   mIdle;
    obs_t mExp;

    function automatic obs_t mk(bit dc, logic [3:0] num, bit clr, bit disp,
                                logic [3:0] f, logic [3:0] s, logic [7:0] st,
                                bit cv, logic [6:0] val, bit to);
        obs_t o;
        o.dc = dc; o.num = num; o.clr = clr; o.disp = disp;
        o.first = f; o.second = s; o.st = st; o.cv = cv; o.val = val; o.to = to;
        return o;
    endfunction

    function automatic void addVec(bit kv, logic [3:0] code, int reps, bit chk,
                                   obs_t expv, string name);
        vec_t v;
        v.kv = kv; v.code = code; v.reps = reps; v.chk = chk;
        v.expv = expv; v.name = name;
        vecs.push_back(v);
    endfunction

    function automatic void modelReset();
        mDigits.delete();
        mShowing  = 1'b0;
        mShowLeft = 0;
        mIdle     = 0;
        mExp      = mk(0, 4'h0, 0, 0, 4'hA, 4'hA, 8'h00, 0, 7'd0, 0);
    endfunction

    function automatic void modelGoIdle();
        mDigits.delete();
        mShowing    = 1'b0;
        mIdle       = 0;
        mExp.disp   = 1'b0;
        mExp.clr    = 1'b1;
        mExp.first  = 4'hA;
        mExp.second = 4'hA;
    endfunction

    function automatic void modelStep(bit kv, logic [3:0] code);
        int   value;
        bit   isClear;
        isClear = kv && (code == 4'hA);
        mExp.dc = 1'b0; mExp.clr = 1'b0; mExp.cv = 1'b0; mExp.to = 1'b0;
        if (kv) mIdle = 0;
        else if (mDigits.size() > 0) mIdle++;
        if (mShowing && !isClear) mShowLeft--;

        if (isClear) begin
            modelGoIdle();
        end else if (mShowing && mShowLeft == 0) begin
            modelGoIdle();
        end else if (TimeoutOn && !kv && mDigits.size() > 0 && mIdle >= int'(TIMEOUT_N)) begin
            modelGoIdle();
            mExp.to = 1'b1;
        end else if (kv && !mShowing) begin
            if (code <= 4'd9 && mDigits.size() < 2) begin
                mDigits.push_back(int'(code));
                mExp.dc  = 1'b1;
                mExp.num = code;
            end else if (code == 4'hB && mDigits.size() > 0) begin
                if (mDigits.size() == 2) begin
                    value      = mDigits[0] * 10 + mDigits[1];
                    mExp.first = 4'(mDigits[0]);
                end else begin
                    value      = mDigits[0];
                    mExp.first = 4'hA;
                end
                mExp.second = 4'(mDigits[mDigits.size() - 1]);
                mExp.val    = 7'(value);
                mExp.cv     = 1'b1;
                mExp.disp   = 1'b1;
                mShowing    = 1'b1;
                mShowLeft   = int'(SHOW_N);
                mDigits.delete();
            end
        end

        if (mShowing) mExp.st = 8'h04;
        else if (mDigits.size() == 0) mExp.st = 8'h00;
        else if (mDigits.size() == 1) mExp.st = 8'h01;
        else mExp.st = 8'h02;
    endfunction

    task automatic applyStimulus(input bit kv, input logic [3:0] code);
        key_valid = kv;
        key_code  = code;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input obs_t expv, input bit chkDigits);
        obs_t act;
        obs_t mask;
        act.dc = digit_changed; act.num = number_input; act.clr = two_digit_clear;
        act.disp = disp_val; act.first = first_val_digit; act.second = second_val_digit;
        act.st = state; act.cv = code_valid; act.val = code_value; act.to = timeout;
        mask = '1;
        if (!chkDigits) begin
            mask.first  = 4'h0;
            mask.second = 4'h0;
        end
        testsRun++;
        if ((act & mask) !== (expv & mask)) begin
            testsFailed++;
            $display("[TB] FAIL %s: got dc=%0b num=%0h clr=%0b disp=%0b dig=%0h/%0h state=%02h cv=%0b val=%0d to=%0b, expected dc=%0b num=%0h clr=%0b disp=%0b dig=%0h/%0h state=%02h cv=%0b val=%0d to=%0b",
                     name, act.dc, act.num, act.clr, act.disp, act.first, act.second,
                     act.st, act.cv, act.val, act.to, expv.dc, expv.num, expv.clr,
                     expv.disp, expv.first, expv.second, expv.st, expv.cv, expv.val, expv.to);
        end
    endtask

    task automatic doReset();
        key_valid = 1'b0;
        key_code  = 4'h0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset", mk(0, 4'h0, 0, 0, 4'hA, 4'hA, 8'h00, 0, 7'd0, 0), 1'b1);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        obs_t e;
        bit   kv;
        logic [3:0] code;
        int   r;

        // Directed entry table: one row per key or idle run.
        addVec(1, 4'h4, 1, 0, mk(1, 4'h4, 0, 0, 4'hA, 4'hA, 8'h01, 0, 7'd0, 0), "key4");
        addVec(1, 4'h7, 1, 0, mk(1, 4'h7, 0, 0, 4'hA, 4'hA, 8'h02, 0, 7'd0, 0), "key7");
        addVec(1, 4'hB, 1, 1, mk(0, 4'h7, 0, 1, 4'h4, 4'h7, 8'h04, 1, 7'd47, 0), "enter47");
        addVec(0, 4'h0, 7, 1, mk(0, 4'h7, 0, 1, 4'h4, 4'h7, 8'h04, 0, 7'd47, 0), "show47");
        addVec(0, 4'h0, 1, 0, mk(0, 4'h7, 1, 0, 4'hA, 4'hA, 8'h00, 0, 7'd47, 0), "expire47");
        addVec(0, 4'h0, 1, 0, mk(0, 4'h7, 0, 0, 4'hA, 4'hA, 8'h00, 0, 7'd47, 0), "oneClearPulse");
        addVec(1, 4'h5, 1, 0, mk(1, 4'h5, 0, 0, 4'hA, 4'hA, 8'h01, 0, 7'd47, 0), "key5");
        addVec(1, 4'hB, 1, 1, mk(0, 4'h5, 0, 1, 4'hA, 4'h5, 8'h04, 1, 7'd5, 0), "enter5");
        addVec(1, 4'h6, 1, 1, mk(0, 4'h5, 0, 1, 4'hA, 4'h5, 8'h04, 0, 7'd5, 0), "digitInShow");
        addVec(1, 4'hB, 1, 1, mk(0, 4'h5, 0, 1, 4'hA, 4'h5, 8'h04, 0, 7'd5, 0), "enterInShow");
        addVec(0, 4'h0, 5, 1, mk(0, 4'h5, 0, 1, 4'hA, 4'h5, 8'h04, 0, 7'd5, 0), "show5");
        addVec(0, 4'h0, 1, 0, mk(0, 4'h5, 1, 0, 4'hA, 4'hA, 8'h00, 0, 7'd5, 0), "expire5");
        addVec(1, 4'h1, 1, 0, mk(1, 4'h1, 0, 0, 4'hA, 4'hA, 8'h01, 0, 7'd5, 0), "key1");
        addVec(1, 4'h2, 1, 0, mk(1, 4'h2, 0, 0, 4'hA, 4'hA, 8'h02, 0, 7'd5, 0), "key2");
        addVec(1, 4'h3, 1, 0, mk(0, 4'h2, 0, 0, 4'hA, 4'hA, 8'h02, 0, 7'd5, 0), "key3Dropped");
        addVec(0, 4'h0, 1, 0, mk(0, 4'h2, 0, 0, 4'hA, 4'hA, 8'h02, 0, 7'd5, 0), "holdTwo");
        addVec(1, 4'hE, 1, 0, mk(0, 4'h2, 0, 0, 4'hA, 4'hA, 8'h02, 0, 7'd5, 0), "invalidKey");
        addVec(1, 4'hA, 1, 0, mk(0, 4'h2, 1, 0, 4'hA, 4'hA, 8'h00, 0, 7'd5, 0), "clearTwo");
        addVec(1, 4'hB, 1, 0, mk(0, 4'h2, 0, 0, 4'hA, 4'hA, 8'h00, 0, 7'd5, 0), "enterInIdle");
        addVec(1, 4'h9, 1, 0, mk(1, 4'h9, 0, 0, 4'hA, 4'hA, 8'h01, 0, 7'd5, 0), "key9");
        addVec(1, 4'hA, 1, 0, mk(0, 4'h9, 1, 0, 4'hA, 4'hA, 8'h00, 0, 7'd5, 0), "clearOne");
        addVec(1, 4'hB, 1, 0, mk(0, 4'h9, 0, 0, 4'hA, 4'hA, 8'h00, 0, 7'd5, 0), "enterAfterClear");
        addVec(1, 4'hA, 1, 0, mk(0, 4'h9, 1, 0, 4'hA, 4'hA, 8'h00, 0, 7'd5, 0), "clearIdle");

        @(negedge clk);
        doReset();

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].reps; k++) begin
                applyStimulus(vecs[i].kv, vecs[i].code);
                checkOutput(vecs[i].name, vecs[i].expv, vecs[i].chk);
            end
        end

        // Inactivity: one digit then TIMEOUT_N quiet cycles.
        applyStimulus(1'b1, 4'h3);
        checkOutput("toKey3", mk(1, 4'h3, 0, 0, 4'hA, 4'hA, 8'h01, 0, 7'd5, 0), 1'b0);
        for (int k = 1; k < int'(TIMEOUT_N); k++) begin
            applyStimulus(1'b0, 4'h0);
            checkOutput("toWait", mk(0, 4'h3, 0, 0, 4'hA, 4'hA, 8'h01, 0, 7'd5, 0), 1'b0);
        end
        applyStimulus(1'b0, 4'h0);
        e = TimeoutOn ? mk(0, 4'h3, 1, 0, 4'hA, 4'hA, 8'h00, 0, 7'd5, 1)
                      : mk(0, 4'h3, 0, 0, 4'hA, 4'hA, 8'h01, 0, 7'd5, 0);
        checkOutput("toExpire", e, 1'b0);
        applyStimulus(1'b1, 4'hA);
        checkOutput("toClear", mk(0, 4'h3, 1, 0, 4'hA, 4'hA, 8'h00, 0, 7'd5, 0), 1'b0);

        // CLEAR arriving in the same cycle the show period ends.
        applyStimulus(1'b1, 4'h8);
        checkOutput("coKey8", mk(1, 4'h8, 0, 0, 4'hA, 4'hA, 8'h01, 0, 7'd5, 0), 1'b0);
        applyStimulus(1'b1, 4'hB);
        checkOutput("coEnter", mk(0, 4'h8, 0, 1, 4'hA, 4'h8, 8'h04, 1, 7'd8, 0), 1'b1);
        for (int k = 1; k < int'(SHOW_N); k++) begin
            applyStimulus(1'b0, 4'h0);
            checkOutput("coShow", mk(0, 4'h8, 0, 1, 4'hA, 4'h8, 8'h04, 0, 7'd8, 0), 1'b1);
        end
        applyStimulus(1'b1, 4'hA);
        checkOutput("coClear", mk(0, 4'h8, 1, 0, 4'hA, 4'hA, 8'h00, 0, 7'd8, 0), 1'b0);
        applyStimulus(1'b0, 4'h0);
        checkOutput("coSinglePulse", mk(0, 4'h8, 0, 0, 4'hA, 4'hA, 8'h00, 0, 7'd8, 0), 1'b0);

        // Reset asserted part-way through a show period.
        applyStimulus(1'b1, 4'h4);
        applyStimulus(1'b1, 4'h7);
        applyStimulus(1'b1, 4'hB);
        applyStimulus(1'b0, 4'h0);
        applyStimulus(1'b0, 4'h0);
        checkOutput("rsShowing", mk(0, 4'h7, 0, 1, 4'h4, 4'h7, 8'h04, 0, 7'd47, 0), 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("rsAsync", mk(0, 4'h0, 0, 0, 4'hA, 4'hA, 8'h00, 0, 7'd0, 0), 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b0, 4'h0);
            checkOutput("rsQuiet", mk(0, 4'h0, 0, 0, 4'hA, 4'hA, 8'h00, 0, 7'd0, 0), 1'b1);
        end

        // Randomised traffic against the reference model, with quiet windows.
        doReset();
        modelReset();
        for (int i = 0; i < 3000; i++) begin
            if ((i % 80) >= 60) kv = 1'b0;
            else kv = ($urandom_range(0, 99) < 35);
            r = int'($urandom_range(0, 19));
            if (r < 10) code = 4'(r);
            else if (r < 15) code = 4'hB;
            else if (r < 17) code = 4'hA;
            else code = 4'($urandom_range(12, 15));
            if (!kv) code = 4'h0;
            applyStimulus(kv, code);
            modelStep(kv, code);
            checkOutput("random", mExp, mExp.disp);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
